// File: rtl/icache_direct.sv
// ---------------------------------------------------------------------------
// icache_direct
//   Direct-mapped, read-only instruction cache for the IF stage.
//   256 lines x 16 bytes (4 words). Hits are answered in the cycle after the
//   request is accepted, and back-to-back hits are accepted every cycle.
//   A miss refills one whole line through a burst read port. kseg1 fetches
//   (tag[19:17] == UC_SEG) bypass the cache with a single-word read and
//   never allocate a line.
//
// Ports
//   clk, resetn                   clock, synchronous active-low reset
//   inst_valid/op/index/tag/offset   fetch request from IF (op ignored)
//   inst_addr_ok                  request accepted this cycle
//   inst_data_ok, inst_rdata      fetched instruction valid this cycle
//   rd_req/type/addr, rd_rdy      read request toward the AXI bridge
//   ret_valid/last/data           read return beats
//
// Configuration
//   ICACHE_PERF_EN  when defined, adds wrapping 32-bit counters hit_cnt,
//                   miss_cnt and uc_cnt as extra outputs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module icache_direct #(
  parameter logic [2:0] UC_SEG = 3'b101
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_valid,
  input  logic        inst_op,
  input  logic [7:0]  inst_index,
  input  logic [19:0] inst_tag,
  input  logic [3:0]  inst_offset,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  output logic        rd_req,
  output logic [2:0]  rd_type,
  output logic [31:0] rd_addr,
  input  logic        rd_rdy,
  input  logic        ret_valid,
  input  logic        ret_last,
  input  logic [31:0] ret_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
  output logic [31:0] uc_cnt
`endif
);

  localparam int LINE_WORDS = 4;
  localparam int LINE_BITS  = LINE_WORDS * 32;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_MISS   = 3'd2;
  localparam logic [2:0] S_REFILL = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  localparam logic [2:0] RD_LINE = 3'b100;
  localparam logic [2:0] RD_WORD = 3'b010;

  // Registered state
  logic [2:0]   state_q,     state_d;
  logic [19:0]  req_tag_q,   req_tag_d;
  logic [7:0]   req_index_q, req_index_d;
  logic [1:0]   req_word_q,  req_word_d;
  logic [1:0]   cnt_q,       cnt_d;
  logic [31:0]  resp_q,      resp_d;
  logic [255:0] valid_q,     valid_d;

  // Storage arrays
  logic [LINE_BITS-1:0] buf_q;
  logic [LINE_BITS-1:0] data_ram [256];
  logic [19:0]          tag_ram  [256];

  // Combinational helpers
  logic                 req_uc;
  logic                 hit;
  logic                 accept;
  logic                 fill_done;
  logic [LINE_BITS-1:0] line_rd;
  logic [LINE_BITS-1:0] beat_line;

  // inst_op and the byte-within-word offset carry no information here.
  logic unused_ok;
  assign unused_ok = ^{inst_op, inst_offset[1:0]};

  assign req_uc  = (req_tag_q[19:17] == UC_SEG);
  assign line_rd = data_ram[req_index_q];
  assign hit     = (state_q == S_LOOKUP) && !req_uc && valid_q[req_index_q] &&
                   (tag_ram[req_index_q] == req_tag_q);

  // addr_ok is held low while reset is asserted so nothing is accepted then.
  assign inst_addr_ok = resetn && ((state_q == S_IDLE) || hit);
  assign accept       = inst_valid && inst_addr_ok;

  assign fill_done = (state_q == S_REFILL) && ret_valid && ret_last;

  // Refill buffer with the current return beat merged in, so the final beat
  // can be written to the data RAM on the same edge it arrives.
  always_comb begin
    beat_line = buf_q;
    if ((state_q == S_REFILL) && ret_valid) begin
      beat_line[{cnt_q, 5'b0} +: 32] = ret_data;
    end
  end

  // NOTE: every signal assigned in an always_comb gets a default first;
  // a path that leaves one unassigned infers a latch.
  always_comb begin
    state_d     = state_q;
    req_tag_d   = req_tag_q;
    req_index_d = req_index_q;
    req_word_d  = req_word_q;
    cnt_d       = cnt_q;
    resp_d      = resp_q;
    valid_d     = valid_q;

    if (accept) begin
      req_tag_d   = inst_tag;
      req_index_d = inst_index;
      req_word_d  = inst_offset[3:2];
    end

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit) begin
          state_d = accept ? S_LOOKUP : S_IDLE;
        end else begin
          state_d = S_MISS;
          cnt_d   = 2'd0;
        end
      end
      S_MISS: begin
        if (rd_rdy) state_d = S_REFILL;
      end
      S_REFILL: begin
        // Extra beats before ret_last simply wrap the 2-bit counter.
        if (ret_valid) cnt_d = cnt_q + 2'd1;
        if (fill_done) begin
          state_d = S_RESP;
          resp_d  = req_uc ? ret_data : beat_line[{req_word_q, 5'b0} +: 32];
          if (!req_uc) valid_d[req_index_q] = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      req_tag_q   <= '0;
      req_index_q <= '0;
      req_word_q  <= '0;
      cnt_q       <= '0;
      resp_q      <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_tag_q   <= req_tag_d;
      req_index_q <= req_index_d;
      req_word_q  <= req_word_d;
      cnt_q       <= cnt_d;
      resp_q      <= resp_d;
      valid_q     <= valid_d;
    end
  end

  // NOTE: the data/tag RAMs and refill buffer are deliberately not reset;
  // the valid bits alone decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    if (resetn && (state_q == S_REFILL) && ret_valid) begin
      buf_q <= beat_line;
    end
    if (resetn && fill_done && !req_uc) begin
      data_ram[req_index_q] <= beat_line;
      tag_ram[req_index_q]  <= req_tag_q;
    end
  end

  // Outputs
  assign inst_data_ok = hit || (state_q == S_RESP);

  always_comb begin
    inst_rdata = 32'd0;
    if (hit)                     inst_rdata = line_rd[{req_word_q, 5'b0} +: 32];
    else if (state_q == S_RESP)  inst_rdata = resp_q;
  end

  always_comb begin
    rd_req  = 1'b0;
    rd_type = 3'b000;
    rd_addr = 32'd0;
    if (state_q == S_MISS) begin
      rd_req = 1'b1;
      if (req_uc) begin
        rd_type = RD_WORD;
        rd_addr = {3'b000, req_tag_q[16:0], req_index_q, req_word_q, 2'b00};
      end else begin
        rd_type = RD_LINE;
        rd_addr = {3'b000, req_tag_q[16:0], req_index_q, 4'b0000};
      end
    end
  end

`ifdef ICACHE_PERF_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      uc_cnt   <= '0;
    end else begin
      if (hit) hit_cnt <= hit_cnt + 32'd1;
      if ((state_q == S_LOOKUP) && !hit) begin
        if (req_uc) uc_cnt   <= uc_cnt + 32'd1;
        else        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// ---------------------------------------------------------------------------
// tb_icache_direct
//   Self-checking bench for icache_direct. A memory model (associative array
//   with a computed default) supplies every read beat, and a cache model of
//   valid bits and tags predicts hit or miss; expected instruction data is
//   always the memory word at the fetched address.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_icache_direct;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_valid;
  logic        inst_op;
  logic [7:0]  inst_index;
  logic [19:0] inst_tag;
  logic [3:0]  inst_offset;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        rd_req;
  logic [2:0]  rd_type;
  logic [31:0] rd_addr;
  logic        rd_rdy;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] ret_data;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt, uc_cnt;
`endif

  icache_direct dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_valid   (inst_valid),
    .inst_op      (inst_op),
    .inst_index   (inst_index),
    .inst_tag     (inst_tag),
    .inst_offset  (inst_offset),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .rd_req       (rd_req),
    .rd_type      (rd_type),
    .rd_addr      (rd_addr),
    .rd_rdy       (rd_rdy),
    .ret_valid    (ret_valid),
    .ret_last     (ret_last),
    .ret_data     (ret_data)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt),
    .uc_cnt       (uc_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory and cache reference model
  logic [31:0] mem [logic [31:0]];
  bit   [255:0] m_valid;
  logic [19:0]  m_tag [256];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'h5a5a, ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_req(input logic [31:0] addr);
    inst_valid  = 1'b1;
    inst_op     = 1'($urandom);
    inst_tag    = addr[31:12];
    inst_index  = addr[11:4];
    inst_offset = addr[3:0];
  endtask

  // One isolated fetch from IDLE; predicts hit/miss from the model and plays
  // the memory side for a miss.
  task automatic fetch(input logic [31:0] addr, input int rdy_delay, input int max_gap);
    logic [19:0] tag;
    logic [7:0]  idx;
    logic        uc, exp_hit;
    logic [31:0] waddr, base;
    int          nb;
    tag     = addr[31:12];
    idx     = addr[11:4];
    uc      = (tag[19:17] == 3'b101);
    exp_hit = !uc && m_valid[idx] && (m_tag[idx] == tag);
    waddr   = {3'b000, addr[28:2], 2'b00};
    base    = uc ? waddr : {3'b000, addr[28:4], 4'b0000};

    drive_req(addr);
    #1 check("addr_ok_idle", 32'(inst_addr_ok), 32'd1);
    tick();
    inst_valid = 1'b0;
    #1;
    if (exp_hit) begin
      check("hit_data_ok", 32'(inst_data_ok), 32'd1);
      check("hit_rdata", inst_rdata, mem_rd(waddr));
      check("hit_rd_req", 32'(rd_req), 32'd0);
      tick();
    end else begin
      check("miss_lookup_data_ok", 32'(inst_data_ok), 32'd0);
      tick();
      check("miss_rd_req", 32'(rd_req), 32'd1);
      check("miss_rd_type", 32'(rd_type), uc ? 32'h2 : 32'h4);
      check("miss_rd_addr", rd_addr, base);
      for (int i = 0; i < rdy_delay; i++) begin
        tick();
        check("miss_rd_req_hold", 32'(rd_req), 32'd1);
      end
      rd_rdy = 1'b1;
      tick();
      rd_rdy = 1'b0;
      #1 check("rd_req_drop", 32'(rd_req), 32'd0);
      nb = uc ? 1 : 4;
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(max_gap)) begin
          tick();
          check("refill_gap_data_ok", 32'(inst_data_ok), 32'd0);
        end
        ret_valid = 1'b1;
        ret_last  = (b == nb - 1);
        ret_data  = mem_rd(base + 32'(4 * b));
        #1 check("refill_data_ok", 32'(inst_data_ok), 32'd0);
        tick();
        ret_valid = 1'b0;
        ret_last  = 1'b0;
      end
      #1;
      check("resp_data_ok", 32'(inst_data_ok), 32'd1);
      check("resp_rdata", inst_rdata, mem_rd(waddr));
      tick();
      check("resp_single", 32'(inst_data_ok), 32'd0);
      if (!uc) begin
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [19:0] tags [4];
    resetn = 1'b0; inst_valid = 1'b0; inst_op = 1'b0; inst_index = '0;
    inst_tag = '0; inst_offset = '0; rd_rdy = 1'b0; ret_valid = 1'b0;
    ret_last = 1'b0; ret_data = '0;
    m_valid = '0;
    mem[32'h0000_0010] = 32'h11;
    mem[32'h0000_0014] = 32'h22;
    mem[32'h0000_0018] = 32'h33;
    mem[32'h0000_001c] = 32'h44;
    mem[32'h1fc0_0000] = 32'h3c1d_8000;

    // Reset state
    tick(); tick();
    check("rst_addr_ok", 32'(inst_addr_ok), 32'd0);
    check("rst_data_ok", 32'(inst_data_ok), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_rd_type", 32'(rd_type), 32'd0);
    check("rst_rd_addr", rd_addr, 32'd0);
    check("rst_rdata", inst_rdata, 32'd0);
    resetn = 1'b1;
    tick();

    // Cold miss: expects rd_addr 0x10 burst and rdata 0x22
    fetch(32'h0000_0014, 2, 0);

    // Hit streak over the same line, back-to-back
    drive_req(32'h0000_0010);
    #1 check("streak_addr_ok0", 32'(inst_addr_ok), 32'd1);
    tick();
    for (int i = 1; i <= 4; i++) begin
      #1;
      check("streak_data_ok", 32'(inst_data_ok), 32'd1);
      check("streak_rdata", inst_rdata, 32'h11 * 32'(i));
      check("streak_rd_req", 32'(rd_req), 32'd0);
      if (i < 4) begin
        drive_req(32'h0000_0010 + 32'(4 * i));
        #1 check("streak_addr_ok", 32'(inst_addr_ok), 32'd1);
      end else begin
        inst_valid = 1'b0;
      end
      tick();
    end
    check("streak_end_data_ok", 32'(inst_data_ok), 32'd0);

    // Uncached twice: never allocates
    fetch(32'hbfc0_0000, 1, 1);
    fetch(32'hbfc0_0000, 0, 0);

`ifdef ICACHE_PERF_EN
    check("perf_hit", hit_cnt, 32'd4);
    check("perf_miss", miss_cnt, 32'd1);
    check("perf_uc", uc_cnt, 32'd2);
`endif

    // Conflict on index 1
    fetch(32'h0000_5014, 1, 1);
    fetch(32'h0000_0018, 0, 0);
    fetch(32'h0000_001c, 0, 0);

    // Reset in the middle of a refill
    drive_req(32'h0000_1234);
    tick();
    inst_valid = 1'b0;
    tick();
    rd_rdy = 1'b1;
    tick();
    rd_rdy = 1'b0;
    for (int b = 0; b < 2; b++) begin
      ret_valid = 1'b1;
      ret_data  = mem_rd(32'h0000_1230 + 32'(4 * b));
      tick();
    end
    ret_valid = 1'b0;
    resetn = 1'b0;
    tick();
    #1;
    check("midrst_addr_ok", 32'(inst_addr_ok), 32'd0);
    check("midrst_data_ok", 32'(inst_data_ok), 32'd0);
    check("midrst_rd_req", 32'(rd_req), 32'd0);
    resetn = 1'b1;
    m_valid = '0;
    for (int b = 2; b < 4; b++) begin
      ret_valid = 1'b1;
      ret_last  = (b == 3);
      ret_data  = mem_rd(32'h0000_1230 + 32'(4 * b));
      #1;
      check("stale_beat_data_ok", 32'(inst_data_ok), 32'd0);
      check("stale_beat_rd_req", 32'(rd_req), 32'd0);
      tick();
    end
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    #1 check("stale_after_data_ok", 32'(inst_data_ok), 32'd0);
    fetch(32'h0000_1234, 0, 0);
    fetch(32'h0000_0014, 0, 0);
    fetch(32'h0000_1238, 0, 0);

    // Randomized fetches over a small conflicting address set
    tags[0] = 20'h00000; tags[1] = 20'h00001; tags[2] = 20'h12345; tags[3] = 20'hbfc00;
    for (int n = 0; n < 60; n++) begin
      a = {tags[$urandom_range(3)], 8'($urandom_range(3)), 4'($urandom)};
      fetch(a, $urandom_range(2), 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
